mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences one shared, variable-latency memory between the
// fetch stage (read-only) and the memory stage (read/write). One transaction
// at a time walks IDLE -> ISSUE -> WAIT -> DONE. Data normally wins a grant,
// but fetch is forced through after STARVE_LIMIT data grants made while
// fetch was waiting. A memory that never answers is cut off after TIMEOUT
// WAIT cycles and raises a sticky error.
module mem_arbiter #(
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fReq,
    input  logic [15:0] fAddr,
    output logic [15:0] fData,
    output logic        fDone,
    output logic        fStall,
    input  logic        dReq,
    input  logic        dWrt,
    input  logic [15:0] dAddr,
    input  logic [15:0] dWrData,
    output logic [15:0] dData,
    output logic        dDone,
    output logic        dStall,
    output logic        memEn,
    output logic        memWr,
    output logic [15:0] memAddr,
    output logic [15:0] memDataIn,
    input  logic [15:0] memDataOut,
    input  logic        memReady,
    output logic        err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [1:0]    state_r;
    logic          ownerData_r;   // 1: data stage owns the transaction, 0: fetch
    logic          memEn_r;
    logic          memWr_r;
    logic [15:0]   memAddr_r;
    logic [15:0]   memDataIn_r;
    logic [15:0]   fData_r;
    logic [15:0]   dData_r;
    logic          fDone_r;
    logic          dDone_r;
    logic          err_r;
    logic [WW-1:0] waitCnt_r;
    logic [SW-1:0] starveCnt_r;

    logic          fetchWins_s;
    logic [WW-1:0] waitNext_s;
    logic          timeout_s;
    logic [15:0]   rdVal_s;

    // Grant decision, wait-counter increment and the value returned to the owner
    always_comb begin
        fetchWins_s = 1'b0;
        if (fReq && (!dReq || (starveCnt_r == STARVE_MAX))) begin
            fetchWins_s = 1'b1;
        end else begin
            fetchWins_s = 1'b0;
        end
        waitNext_s = waitCnt_r + WW'(1'b1);
        timeout_s  = (waitNext_s == WAIT_LIMIT);
        rdVal_s    = 16'h0000;
        if (memReady) begin
            rdVal_s = memDataOut;
        end else begin
            rdVal_s = 16'h0000;
        end
    end

    // Transaction sequencer, arbitration bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            ownerData_r <= 1'b0;
            memEn_r     <= 1'b0;
            memWr_r     <= 1'b0;
            memAddr_r   <= 16'h0000;
            memDataIn_r <= 16'h0000;
            fData_r     <= 16'h0000;
            dData_r     <= 16'h0000;
            fDone_r     <= 1'b0;
            dDone_r     <= 1'b0;
            err_r       <= 1'b0;
            waitCnt_r   <= {WW{1'b0}};
            starveCnt_r <= {SW{1'b0}};
        end else begin
            // strobes are single-cycle unless re-armed below
            memEn_r <= 1'b0;
            fDone_r <= 1'b0;
            dDone_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fReq || dReq) begin
                        state_r <= ST_ISSUE;
                        memEn_r <= 1'b1;
                        if (fetchWins_s) begin
                            ownerData_r <= 1'b0;
                            memAddr_r   <= fAddr;
                            memDataIn_r <= 16'h0000;
                            memWr_r     <= 1'b0;
                            starveCnt_r <= {SW{1'b0}};
                        end else begin
                            ownerData_r <= 1'b1;
                            memAddr_r   <= dAddr;
                            memDataIn_r <= dWrData;
                            memWr_r     <= dWrt;
                            // only grants that bypass a waiting fetch count towards starvation
                            if (fReq) begin
                                if (starveCnt_r != STARVE_MAX) begin
                                    starveCnt_r <= starveCnt_r + SW'(1'b1);
                                end else begin
                                    starveCnt_r <= starveCnt_r;
                                end
                            end else begin
                                starveCnt_r <= {SW{1'b0}};
                            end
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // memReady takes priority over a timeout landing on the same cycle
                    if (memReady || timeout_s) begin
                        state_r <= ST_DONE;
                        if (!memReady) begin
                            err_r <= 1'b1;
                        end else begin
                            err_r <= err_r;
                        end
                        if (ownerData_r) begin
                            dDone_r <= 1'b1;
                            if (!memWr_r) begin
                                dData_r <= rdVal_s;
                            end else begin
                                dData_r <= dData_r;
                            end
                        end else begin
                            fDone_r <= 1'b1;
                            fData_r <= rdVal_s;
                        end
                    end else begin
                        waitCnt_r <= waitNext_s;
                    end
                end
                ST_DONE: begin
                    waitCnt_r <= {WW{1'b0}};
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign memEn     = memEn_r;
    assign memWr     = memWr_r;
    assign memAddr   = memAddr_r;
    assign memDataIn = memDataIn_r;
    assign fData     = fData_r;
    assign dData     = dData_r;
    assign fDone     = fDone_r;
    assign dDone     = dDone_r;
    assign err       = err_r;
    assign fStall    = fReq & ~fDone_r;
    assign dStall    = dReq & ~dDone_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions against a
// transaction-level model of the arbiter (grant rule, latency, data returns).
module tb_mem_arbiter;

    localparam int TIMEOUT      = 15;
    localparam int STARVE_LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fReq = 1'b0;
    logic [15:0] fAddr = 16'h0;
    logic [15:0] fData;
    logic        fDone, fStall;
    logic        dReq = 1'b0;
    logic        dWrt = 1'b0;
    logic [15:0] dAddr = 16'h0;
    logic [15:0] dWrData = 16'h0;
    logic [15:0] dData;
    logic        dDone, dStall;
    logic        memEn, memWr;
    logic [15:0] memAddr, memDataIn;
    logic [15:0] memDataOut = 16'h0;
    logic        memReady = 1'b0;
    logic        err;

    int checks = 0;
    int failures = 0;

    // model state
    logic [15:0] mF = 16'h0;
    logic [15:0] mD = 16'h0;
    logic        mErr = 1'b0;
    int          mStarve = 0;

    // observations from the last transaction
    int          issueCyc, doneCyc, fStallCnt, dStallCnt;
    logic [15:0] oAddr, oDin;
    logic        oWr, gotF, gotD, fStallDone, dStallDone;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .fReq(fReq), .fAddr(fAddr), .fData(fData), .fDone(fDone), .fStall(fStall),
        .dReq(dReq), .dWrt(dWrt), .dAddr(dAddr), .dWrData(dWrData),
        .dData(dData), .dDone(dDone), .dStall(dStall),
        .memEn(memEn), .memWr(memWr), .memAddr(memAddr), .memDataIn(memDataIn),
        .memDataOut(memDataOut), .memReady(memReady), .err(err)
    );

    always #5 clk = ~clk;

    // Arbitration rule: data first unless fetch has been passed over STARVE_LIMIT times
    task automatic modelGrant(output bit fWin);
        fWin = fReq && (!dReq || mStarve == STARVE_LIMIT);
        if (fWin) mStarve = 0;
        else if (fReq) mStarve = (mStarve < STARVE_LIMIT) ? mStarve + 1 : STARVE_LIMIT;
        else mStarve = 0;
    endtask

    // Result of a completed transaction; rdyWait==0 means the memory never answered
    task automatic modelComplete(input bit fWin, input bit wr, input int rdyWait, input logic [15:0] rd);
        logic [15:0] v;
        v = rd;
        if (rdyWait == 0) begin
            mErr = 1'b1;
            v = 16'h0;
        end
        if (fWin) mF = v;
        else if (!wr) mD = v;
    endtask

    // Memory responder: called at a negedge after requests are set; returns at
    // the negedge of the done cycle (or after a bounded budget, doneCyc = -1).
    // Cycle numbers are relative: cycle 0 is the cycle the caller set requests in.
    task automatic runTxn(input int rdyWait, input logic [15:0] rd, input bit earlyRdy, input bit dropReq);
        issueCyc = -1; doneCyc = -1; fStallCnt = 0; dStallCnt = 0;
        gotF = 1'b0; gotD = 1'b0; fStallDone = 1'b0; dStallDone = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (memEn && issueCyc < 0) begin
                issueCyc = c; oAddr = memAddr; oWr = memWr; oDin = memDataIn;
            end
            if (fDone || dDone) begin
                doneCyc = c; gotF = fDone; gotD = dDone;
                fStallDone = fStall; dStallDone = dStall;
                break;
            end
            if (fStall) fStallCnt++;
            if (dStall) dStallCnt++;
            if (dropReq && c == issueCyc) begin
                fReq = 1'b0; dReq = 1'b0;
            end
            if (issueCyc < 0 || c == issueCyc) memReady = earlyRdy;
            else memReady = (rdyWait != 0 && c == issueCyc + rdyWait);
            memDataOut = memReady ? rd : 16'($urandom);
        end
        memReady = 1'b0;
    endtask

    task automatic endTxn();
        fReq = 1'b0; dReq = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++; if ({memEn, memWr, fDone, dDone, err} !== 5'b0) begin failures++; $display("FAIL reset_flags: got %b expected 00000", {memEn, memWr, fDone, dDone, err}); end
        checks++; if ({memAddr, memDataIn} !== 32'h0) begin failures++; $display("FAIL reset_mem_bus: got %h expected 0", {memAddr, memDataIn}); end
        checks++; if ({fData, dData} !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", {fData, dData}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fetch_read();
        bit fWin;
        fReq = 1'b1; fAddr = 16'h0040;
        modelGrant(fWin);
        #1;
        checks++; if (fStall !== 1'b1) begin failures++; $display("FAIL fetch_stall_c0: got %b expected 1", fStall); end
        runTxn(1, 16'hA5A5, 1'b0, 1'b0);
        modelComplete(fWin, 1'b0, 1, 16'hA5A5);
        checks++; if (issueCyc !== 1) begin failures++; $display("FAIL fetch_issue_cycle: got %0d expected 1", issueCyc); end
        checks++; if (oAddr !== 16'h0040 || oWr !== 1'b0) begin failures++; $display("FAIL fetch_issue_bus: got addr=%h wr=%b expected addr=0040 wr=0", oAddr, oWr); end
        checks++; if (doneCyc !== 3 || gotF !== 1'b1 || gotD !== 1'b0) begin failures++; $display("FAIL fetch_done: got cyc=%0d f=%b d=%b expected cyc=3 f=1 d=0", doneCyc, gotF, gotD); end
        checks++; if (fData !== 16'hA5A5) begin failures++; $display("FAIL fetch_data: got %h expected a5a5", fData); end
        checks++; if (fStallCnt !== 2 || fStallDone !== 1'b0) begin failures++; $display("FAIL fetch_stall: got cnt=%0d atDone=%b expected cnt=2 atDone=0", fStallCnt, fStallDone); end
        endTxn();
    endtask

    task automatic test_data_write();
        bit fWin;
        dReq = 1'b1; dWrt = 1'b1; dAddr = 16'h1000; dWrData = 16'hBEEF;
        modelGrant(fWin);
        runTxn(3, 16'h1234, 1'b0, 1'b0);
        modelComplete(fWin, 1'b1, 3, 16'h1234);
        checks++; if (oWr !== 1'b1 || oDin !== 16'hBEEF || oAddr !== 16'h1000) begin failures++; $display("FAIL write_issue_bus: got wr=%b din=%h addr=%h expected wr=1 din=beef addr=1000", oWr, oDin, oAddr); end
        checks++; if (doneCyc !== 5 || gotD !== 1'b1 || gotF !== 1'b0) begin failures++; $display("FAIL write_done: got cyc=%0d d=%b f=%b expected cyc=5 d=1 f=0", doneCyc, gotD, gotF); end
        checks++; if (dData !== mD || dData !== 16'h0) begin failures++; $display("FAIL write_ddata_kept: got %h expected 0000", dData); end
        dWrt = 1'b0;
        endTxn();
    endtask

    task automatic test_back_to_back();
        bit fWin;
        int lat;
        logic [15:0] rd;
        fReq = 1'b1; dReq = 1'b1; dWrt = 1'b0;
        fAddr = 16'($urandom); dAddr = 16'($urandom);
        for (int i = 0; i < 6; i++) begin
            lat = $urandom_range(1, 4);
            rd = 16'($urandom);
            modelGrant(fWin);
            runTxn(lat, rd, 1'b0, 1'b0);
            modelComplete(fWin, 1'b0, lat, rd);
            checks++; if (gotF !== fWin || fWin !== (i % 3 == 2)) begin failures++; $display("FAIL b2b_owner[%0d]: got fetch=%b expected fetch=%b", i, gotF, (i % 3 == 2)); end
            checks++; if (issueCyc !== (i == 0 ? 1 : 2) || doneCyc !== issueCyc + lat + 1) begin failures++; $display("FAIL b2b_timing[%0d]: got issue=%0d done=%0d lat=%0d", i, issueCyc, doneCyc, lat); end
            checks++; if ((fWin ? dStallDone : fStallDone) !== 1'b1 || (fWin ? dStallCnt : fStallCnt) !== doneCyc - 1) begin failures++; $display("FAIL b2b_loser_stall[%0d]: got atDone=%b cnt=%0d expected 1 and %0d", i, fWin ? dStallDone : fStallDone, fWin ? dStallCnt : fStallCnt, doneCyc - 1); end
            checks++; if (fData !== mF || dData !== mD) begin failures++; $display("FAIL b2b_data[%0d]: got f=%h d=%h expected f=%h d=%h", i, fData, dData, mF, mD); end
        end
        endTxn();
    endtask

    task automatic test_ready_at_limit();
        bit fWin;
        logic [15:0] rd;
        rd = 16'($urandom);
        dReq = 1'b1; dWrt = 1'b0; dAddr = 16'($urandom);
        modelGrant(fWin);
        runTxn(TIMEOUT, rd, 1'b0, 1'b0);
        modelComplete(fWin, 1'b0, TIMEOUT, rd);
        checks++; if (doneCyc !== 1 + TIMEOUT + 1 || err !== 1'b0 || dData !== rd) begin failures++; $display("FAIL ready_at_limit: got done=%0d err=%b d=%h expected done=%0d err=0 d=%h", doneCyc, err, dData, TIMEOUT + 2, rd); end
        endTxn();
    endtask

    task automatic test_timeout();
        bit fWin;
        logic [15:0] rd;
        dReq = 1'b1; dWrt = 1'b0; dAddr = 16'h2222;
        modelGrant(fWin);
        runTxn(0, 16'hFFFF, 1'b0, 1'b0);
        modelComplete(fWin, 1'b0, 0, 16'hFFFF);
        checks++; if (doneCyc !== TIMEOUT + 2 || gotD !== 1'b1) begin failures++; $display("FAIL timeout_done: got cyc=%0d d=%b expected cyc=%0d d=1", doneCyc, gotD, TIMEOUT + 2); end
        checks++; if (err !== 1'b1 || dData !== 16'h0) begin failures++; $display("FAIL timeout_err: got err=%b d=%h expected err=1 d=0000", err, dData); end
        endTxn();
        rd = 16'($urandom);
        fReq = 1'b1; fAddr = 16'($urandom);
        modelGrant(fWin);
        runTxn(2, rd, 1'b0, 1'b0);
        modelComplete(fWin, 1'b0, 2, rd);
        checks++; if (doneCyc !== 4 || fData !== rd || err !== mErr) begin failures++; $display("FAIL after_timeout: got done=%0d f=%h err=%b expected done=4 f=%h err=1", doneCyc, fData, err, rd); end
        endTxn();
    endtask

    task automatic test_drop_request();
        bit fWin;
        logic [15:0] rd;
        rd = 16'($urandom);
        fReq = 1'b1; fAddr = 16'($urandom);
        modelGrant(fWin);
        runTxn(3, rd, 1'b0, 1'b1);
        modelComplete(fWin, 1'b0, 3, rd);
        checks++; if (doneCyc !== 5 || gotF !== 1'b1 || fData !== rd) begin failures++; $display("FAIL drop_request: got done=%0d f=%b data=%h expected done=5 f=1 data=%h", doneCyc, gotF, fData, rd); end
        endTxn();
    endtask

    task automatic test_ready_ignored();
        bit fWin;
        bit seen;
        logic [15:0] rd;
        seen = 1'b0;
        memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            memDataOut = 16'($urandom);
            @(negedge clk);
            if (memEn || fDone || dDone) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || fData !== mF || dData !== mD) begin failures++; $display("FAIL idle_ready: got activity=%b f=%h d=%h expected 0 f=%h d=%h", seen, fData, dData, mF, mD); end
        rd = 16'($urandom);
        fReq = 1'b1; fAddr = 16'($urandom);
        memDataOut = 16'($urandom);
        modelGrant(fWin);
        runTxn(3, rd, 1'b1, 1'b0);
        modelComplete(fWin, 1'b0, 3, rd);
        checks++; if (doneCyc !== 5 || fData !== rd) begin failures++; $display("FAIL issue_ready: got done=%0d f=%h expected done=5 f=%h", doneCyc, fData, rd); end
        endTxn();
    endtask

    task automatic test_reset_mid();
        bit fWin;
        bit seen;
        logic [15:0] rd;
        dReq = 1'b1; dWrt = 1'b0; dAddr = 16'($urandom);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (memEn !== 1'b0 || fDone !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_mid: got memEn=%b fDone=%b err=%b expected 0 0 0", memEn, fDone, err); end
        mF = 16'h0; mD = 16'h0; mErr = 1'b0; mStarve = 0;
        dReq = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (memEn || fDone || dDone) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || dData !== 16'h0) begin failures++; $display("FAIL reset_no_done: got activity=%b d=%h expected 0 d=0000", seen, dData); end
        rd = 16'($urandom);
        fReq = 1'b1; fAddr = 16'($urandom);
        modelGrant(fWin);
        runTxn(1, rd, 1'b0, 1'b0);
        modelComplete(fWin, 1'b0, 1, rd);
        checks++; if (doneCyc !== 3 || fData !== rd) begin failures++; $display("FAIL reset_fresh: got done=%0d f=%h expected done=3 f=%h", doneCyc, fData, rd); end
        endTxn();
    endtask

    task automatic test_random();
        bit fWin, expWr;
        int lat;
        logic [15:0] rd, expAddr;
        for (int i = 0; i < 40; i++) begin
            fReq = 1'($urandom_range(0, 1));
            dReq = 1'($urandom_range(0, 1));
            if (!fReq && !dReq) dReq = 1'b1;
            dWrt = 1'($urandom_range(0, 1));
            fAddr = 16'($urandom); dAddr = 16'($urandom); dWrData = 16'($urandom);
            lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            rd = 16'($urandom);
            modelGrant(fWin);
            expAddr = fWin ? fAddr : dAddr;
            expWr = fWin ? 1'b0 : dWrt;
            runTxn(lat, rd, 1'b0, 1'b0);
            modelComplete(fWin, expWr, lat, rd);
            checks++; if (gotF !== fWin || gotD !== !fWin) begin failures++; $display("FAIL rnd_owner[%0d]: got f=%b d=%b expected f=%b", i, gotF, gotD, fWin); end
            checks++; if (oAddr !== expAddr || oWr !== expWr) begin failures++; $display("FAIL rnd_issue[%0d]: got addr=%h wr=%b expected addr=%h wr=%b", i, oAddr, oWr, expAddr, expWr); end
            if (expWr) begin
                checks++; if (oDin !== dWrData) begin failures++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", i, oDin, dWrData); end
            end
            checks++; if (issueCyc !== 1 || doneCyc !== 1 + (lat == 0 ? TIMEOUT : lat) + 1) begin failures++; $display("FAIL rnd_timing[%0d]: got issue=%0d done=%0d lat=%0d", i, issueCyc, doneCyc, lat); end
            checks++; if (fData !== mF || dData !== mD || err !== mErr) begin failures++; $display("FAIL rnd_state[%0d]: got f=%h d=%h err=%b expected f=%h d=%h err=%b", i, fData, dData, err, mF, mD, mErr); end
            endTxn();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_data_write();
        test_back_to_back();
        test_ready_at_limit();
        test_timeout();
        test_drop_request();
        test_ready_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
